// File: rtl/npu_pkg.sv
// Shared constants and types for the NPU MAC engine: host address map,
// command/config bit positions, sequencer states and the config register layout.
package npu_pkg;

    localparam logic [2:0] SEL_WIN   = 3'd1;
    localparam logic [2:0] SEL_WGT   = 3'd2;
    localparam logic [2:0] SEL_CFG   = 3'd3;
    localparam logic [2:0] SEL_CMD   = 3'd4;
    localparam logic [2:0] SEL_STAT  = 3'd5;
    localparam logic [2:0] SEL_POP   = 3'd6;
    localparam logic [2:0] SEL_CFGRD = 3'd7;

    localparam int CMD_START   = 0;
    localparam int CMD_FLUSH   = 1;
    localparam int CMD_CLR_ERR = 2;

    localparam int CFG_RELU  = 0;
    localparam int CFG_XSIGN = 1;
    localparam int CFG_SHIFT = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [4:0] shift;
        logic       x_signed;
        logic       relu_en;
    } cfg_t;

endpackage

// File: rtl/npu_res_fifo.sv
// Result FIFO: synchronous, power-of-two DEPTH, combinational head (dout) with registered pointers.
// Latency: a push is visible in count/dout after the writing edge; a pop advances the head on its edge.
// Backpressure: push when full and pop when empty are dropped; clr empties the queue at once.
module npu_res_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     rst_ni,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/npu_mac_array.sv
// Multi-channel MAC engine: host-loaded window/weights, self-sequenced tap loop, requantised results into a FIFO.
// Latency: start at edge 0 gives done at edge TAPS+NUM_PE+1; host reads return data the cycle after the request.
// Backpressure: a start is admitted only with NUM_PE free FIFO slots, so DRAIN never stalls; a rejected start sets err[2].
module npu_mac_array
    import npu_pkg::*;
#(
    parameter int K_H        = 3,
    parameter int K_W        = 3,
    parameter int NUM_PE     = 4,
    parameter int DW         = 8,
    parameter int ACC_W      = 24,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_ni,
    input  logic        ena,
    input  logic        wea,
    input  logic [15:0] addra,
    input  logic [31:0] dina,
    output logic [31:0] douta
);
    localparam int TAPS = K_H * K_W;
    localparam int TW   = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int PW   = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int FAW  = $clog2(FIFO_DEPTH);
    localparam int PRW  = 2 * DW + 1;
    localparam logic [TW-1:0] LAST_TAP  = TW'(TAPS - 1);
    localparam logic [PW-1:0] LAST_PE   = PW'(NUM_PE - 1);
    localparam logic [FAW:0]  START_LIM = (FAW+1)'(FIFO_DEPTH - NUM_PE);

    if (ACC_W < 2 * DW + 1 + $clog2(TAPS) || TAPS > 64 || NUM_PE > 16 || DW > 8 ||
        FIFO_DEPTH < NUM_PE || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_chk
        $error("npu_mac_array: illegal parameter combination");
    end

    logic [2:0]   sel;
    logic [3:0]   pe_idx;
    logic [7:0]   word;
    logic         wr_en, rd_en, busy, load_sel, load_ok, load_err;
    logic         cmd_wr, flush, start_idle, start_ok, start_rej, pop_req, pop_err;
    logic         addr_unused;
    state_e       state;
    cfg_t         cfg;
    logic         done;
    logic [3:1]   err;
    logic [TW-1:0] tap_cnt;
    logic [PW-1:0] pe_cnt;
    logic [DW-1:0] x_buf [TAPS];
    logic [DW-1:0] w_buf [NUM_PE][TAPS];
    logic [DW-1:0] x_cur;
    logic signed [DW:0] x_ext;
    logic [31:0]  lane_res [NUM_PE];
    logic         fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [31:0]  fifo_dout;
    logic [FAW:0] fifo_count;

    assign sel         = addra[14:12];
    assign pe_idx      = addra[11:8];
    assign word        = addra[7:0];
    assign addr_unused = addra[15];
    assign wr_en       = ena && wea;
    assign rd_en       = ena && !wea;
    assign busy        = (state != S_IDLE);
    assign load_sel    = (sel == SEL_WIN) || (sel == SEL_WGT) || (sel == SEL_CFG);
    assign load_ok     = wr_en && load_sel && !busy;
    assign load_err    = wr_en && load_sel && busy;
    assign cmd_wr      = wr_en && (sel == SEL_CMD);
    assign flush       = cmd_wr && dina[CMD_FLUSH];
    assign start_idle  = cmd_wr && dina[CMD_START] && !dina[CMD_FLUSH] && !busy;
    assign start_ok    = start_idle && (fifo_count <= START_LIM);
    assign start_rej   = start_idle && !start_ok;
    assign pop_req     = rd_en && (sel == SEL_POP);
    assign fifo_pop    = pop_req && !fifo_empty;
    assign pop_err     = pop_req && fifo_empty;
    assign fifo_push   = (state == S_DRAIN) && !fifo_full && !flush;

    // Byte b of word w carries tap 4w+b; taps past the window simply match no register.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int t = 0; t < TAPS; t++) begin
                x_buf[t] <= '0;
                for (int p = 0; p < NUM_PE; p++) w_buf[p][t] <= '0;
            end
        end else if (load_ok) begin
            for (int t = 0; t < TAPS; t++) begin
                if (sel == SEL_WIN && word == 8'(t / 4)) x_buf[t] <= dina[(t % 4) * 8 +: DW];
                for (int p = 0; p < NUM_PE; p++) begin
                    if (sel == SEL_WGT && pe_idx == 4'(p) && word == 8'(t / 4))
                        w_buf[p][t] <= dina[(t % 4) * 8 +: DW];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg <= '0;
        end else if (load_ok && sel == SEL_CFG) begin
            cfg <= '{shift: dina[CFG_SHIFT +: 5], x_signed: dina[CFG_XSIGN], relu_en: dina[CFG_RELU]};
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= S_IDLE;
            tap_cnt <= '0;
            pe_cnt  <= '0;
            done    <= 1'b0;
        end else if (flush) begin
            state   <= S_IDLE;
            tap_cnt <= '0;
            pe_cnt  <= '0;
            done    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start_ok) begin
                    state   <= S_RUN;
                    tap_cnt <= '0;
                    done    <= 1'b0;
                end
                S_RUN: begin
                    tap_cnt <= tap_cnt + 1'b1;
                    if (tap_cnt == LAST_TAP) begin
                        state  <= S_DRAIN;
                        pe_cnt <= '0;
                    end
                end
                S_DRAIN: begin
                    pe_cnt <= pe_cnt + 1'b1;
                    if (pe_cnt == LAST_PE) state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            err <= '0;
        end else if (cmd_wr && dina[CMD_CLR_ERR]) begin
            err <= {pop_err, start_rej, load_err};
        end else begin
            err <= err | {pop_err, start_rej, load_err};
        end
    end

    assign x_cur = x_buf[tap_cnt];
    assign x_ext = {cfg.x_signed & x_cur[DW-1], x_cur};

    for (genvar p = 0; p < NUM_PE; p++) begin : g_lane
        logic signed [DW-1:0]    w_cur;
        logic signed [PRW-1:0]   prod;
        logic signed [ACC_W-1:0] acc;
        logic signed [ACC_W-1:0] acc_sh;

        assign w_cur = w_buf[p][tap_cnt];
        assign prod  = PRW'(x_ext) * PRW'(w_cur);

        always_ff @(posedge clk or negedge rst_ni) begin
            if (!rst_ni) begin
                acc <= '0;
            end else if (flush || start_ok) begin
                acc <= '0;
            end else if (state == S_RUN) begin
                acc <= acc + ACC_W'(prod);
            end
        end

        assign acc_sh      = acc >>> cfg.shift;
        assign lane_res[p] = (cfg.relu_en && acc[ACC_W-1]) ? 32'd0 : 32'(acc_sh);
    end

    npu_res_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32)
    ) u_res_fifo (
        .clk    (clk),
        .rst_ni (rst_ni),
        .clr    (flush),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .din    (lane_res[pe_cnt]),
        .dout   (fifo_dout),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            douta <= '0;
        end else if (rd_en) begin
            case (sel)
                SEL_STAT:  douta <= {16'd0, 8'(fifo_count), 3'd0, err, done, busy};
                SEL_POP:   douta <= fifo_empty ? 32'd0 : fifo_dout;
                SEL_CFGRD: douta <= {25'd0, cfg};
                default:   douta <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_npu_mac_array.sv
// Bench for npu_mac_array: reads queue their expected value, a negedge monitor compares douta;
// expectations come from an arithmetic model of window/weights/config/FIFO kept here.
module tb_npu_mac_array;
    localparam int TAPS   = 9;
    localparam int NUM_PE = 4;
    localparam int DEPTH  = 8;
    localparam int RUN_WAIT = TAPS + NUM_PE + 2;
    localparam logic [2:0] A_WIN = 3'd1, A_WGT = 3'd2, A_CFG = 3'd3, A_CMD = 3'd4;
    localparam logic [2:0] A_STAT = 3'd5, A_POP = 3'd6, A_CFGRD = 3'd7;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        ena = 1'b0;
    logic        wea = 1'b0;
    logic [15:0] addra = '0;
    logic [31:0] dina = '0;
    logic [31:0] douta;

    npu_mac_array #(
        .K_H(3), .K_W(3), .NUM_PE(NUM_PE), .DW(8), .ACC_W(24), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_ni(rst_ni), .ena(ena), .wea(wea),
        .addra(addra), .dina(dina), .douta(douta)
    );

    always #5 clk = ~clk;

    logic [31:0] exp_q[$];
    logic [31:0] mask_q[$];
    string       name_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic        rd_pend = 1'b0;
    bit          force_chk = 1'b0;
    bit          end_req = 1'b0;
    logic [31:0] mon_e, mon_m;
    string       mon_nm;

    always @(posedge clk) rd_pend <= ena && !wea;

    always @(negedge clk) begin
        if (rd_pend || force_chk) begin
            n_chk = n_chk + 1;
            if (exp_q.size() == 0) begin
                n_err = n_err + 1;
                $display("FAIL unexpected_read: got %h, required no pending read", douta);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_m  = mask_q.pop_front();
                mon_nm = name_q.pop_front();
                if ((douta & mon_m) !== (mon_e & mon_m)) begin
                    n_err = n_err + 1;
                    $display("FAIL %s: got %h required %h (mask %h)", mon_nm, douta, mon_e, mon_m);
                end
            end
        end
        if (end_req) begin
            n_chk = n_chk + 1;
            if (exp_q.size() != 0) begin
                n_err = n_err + 1;
                $display("FAIL leftover_reads: got %0d unanswered, required 0", exp_q.size());
            end
        end
    end

    // Reference model
    int          mx[TAPS];
    int          mw[NUM_PE][TAPS];
    bit          m_relu, m_xs;
    int          m_sh;
    logic [31:0] mfifo[$];
    logic [3:1]  merr;
    bit          mdone;

    function automatic void model_reset();
        for (int t = 0; t < TAPS; t++) begin
            mx[t] = 0;
            for (int p = 0; p < NUM_PE; p++) mw[p][t] = 0;
        end
        m_relu = 0; m_xs = 0; m_sh = 0; merr = '0; mdone = 0;
        mfifo.delete();
    endfunction

    function automatic logic [31:0] m_post(input int a);
        if (m_relu && a < 0) return 32'd0;
        return 32'(a >>> m_sh);
    endfunction

    function automatic void model_run();
        int sum, xv;
        if (DEPTH - mfifo.size() < NUM_PE) begin
            merr[2] = 1'b1;
            return;
        end
        for (int p = 0; p < NUM_PE; p++) begin
            sum = 0;
            for (int t = 0; t < TAPS; t++) begin
                xv  = (m_xs && mx[t] > 127) ? mx[t] - 256 : mx[t];
                sum = sum + xv * mw[p][t];
            end
            mfifo.push_back(m_post(sum));
        end
        mdone = 1'b1;
    endfunction

    function automatic logic [31:0] m_status();
        return {16'd0, 8'(mfifo.size()), 3'd0, merr, mdone, 1'b0};
    endfunction

    function automatic logic [31:0] m_cfg();
        return {25'd0, 5'(m_sh), m_xs, m_relu};
    endfunction

    // Host port driving
    task automatic bus(input bit we, input logic [2:0] sel, input int pe, input int wd, input logic [31:0] d);
        @(negedge clk);
        ena = 1'b1; wea = we; addra = {1'b0, sel, 4'(pe), 8'(wd)}; dina = d;
        @(posedge clk);
        #1 ena = 1'b0; wea = 1'b0;
    endtask

    task automatic wr(input logic [2:0] sel, input int pe, input int wd, input logic [31:0] d);
        bus(1'b1, sel, pe, wd, d);
    endtask

    task automatic rd(input logic [2:0] sel, input logic [31:0] e, input logic [31:0] m, input string nm);
        exp_q.push_back(e); mask_q.push_back(m); name_q.push_back(nm);
        bus(1'b0, sel, 0, 0, 32'd0);
    endtask

    task automatic force_check(input logic [31:0] e, input string nm);
        exp_q.push_back(e); mask_q.push_back('1); name_q.push_back(nm);
        force_chk = 1'b1;
        @(negedge clk);
        #1 force_chk = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // One word past the window is written with junk to show out-of-range taps are dropped.
    task automatic load_x();
        for (int wd = 0; wd <= (TAPS + 3) / 4; wd++) begin
            logic [31:0] d;
            for (int k = 0; k < 4; k++)
                d[k*8 +: 8] = (4*wd + k < TAPS) ? 8'(mx[4*wd + k]) : 8'($urandom);
            wr(A_WIN, 0, wd, d);
        end
    endtask

    task automatic load_w();
        for (int p = 0; p < NUM_PE; p++) begin
            for (int wd = 0; wd <= (TAPS + 3) / 4; wd++) begin
                logic [31:0] d;
                for (int k = 0; k < 4; k++)
                    d[k*8 +: 8] = (4*wd + k < TAPS) ? 8'(mw[p][4*wd + k]) : 8'($urandom);
                wr(A_WGT, p, wd, d);
            end
        end
        wr(A_WGT, NUM_PE, 0, $urandom);
    endtask

    task automatic set_cfg(input bit relu, input bit xs, input int sh);
        m_relu = relu; m_xs = xs; m_sh = sh;
        wr(A_CFG, 0, 0, m_cfg());
    endtask

    task automatic run();
        wr(A_CMD, 0, 0, 32'h1);
        idle(RUN_WAIT);
        model_run();
    endtask

    task automatic pop_one(input string nm);
        logic [31:0] e;
        if (mfifo.size() == 0) begin
            e = 32'd0;
            merr[3] = 1'b1;
        end else begin
            e = mfifo.pop_front();
        end
        rd(A_POP, e, '1, nm);
    endtask

    task automatic pop_n(input int n, input string nm);
        repeat (n) pop_one(nm);
    endtask

    task automatic chk_status(input string nm);
        rd(A_STAT, m_status(), '1, nm);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        idle(3);
        force_check(32'd0, "reset_douta");
        rst_ni = 1'b1;
        chk_status("reset_status");
        rd(A_CFGRD, 32'd0, '1, "reset_cfg");

        // x=1, PE0 w=2, PE1 w=-1, others 0; cycle-exact busy/done
        for (int t = 0; t < TAPS; t++) begin
            mx[t] = 1; mw[0][t] = 2; mw[1][t] = -1; mw[2][t] = 0; mw[3][t] = 0;
        end
        load_x(); load_w(); set_cfg(0, 0, 0);
        wr(A_CMD, 0, 0, 32'h1);
        idle(13);
        rd(A_STAT, 32'h1, 32'h3, "busy_at_edge14");
        model_run();
        chk_status("done_at_edge15");
        rd(A_POP, 32'd18, '1, "t1_pe0");
        rd(A_POP, 32'hFFFF_FFF7, '1, "t1_pe1");
        rd(A_POP, 32'd0, '1, "t1_pe2");
        rd(A_POP, 32'd0, '1, "t1_pe3");
        mfifo.delete();

        set_cfg(1, 0, 2);
        rd(A_CFGRD, 32'h9, '1, "cfg_readback");
        run(); pop_n(NUM_PE, "relu_shift_pop");

        for (int t = 0; t < TAPS; t++) begin
            mx[t] = 255;
            for (int p = 0; p < NUM_PE; p++) mw[p][t] = 1;
        end
        load_x(); load_w();
        set_cfg(0, 0, 0); run();
        rd(A_POP, 32'd2295, '1, "x_unsigned_literal");
        void'(mfifo.pop_front());
        pop_n(NUM_PE - 1, "x_unsigned_pop");
        set_cfg(0, 1, 0); run(); pop_n(NUM_PE, "x_signed_pop");

        // Admission control
        run(); run();
        chk_status("two_runs_count8");
        run();
        chk_status("third_start_rejected");
        pop_n(NUM_PE, "admit_pop_a");
        run();
        chk_status("readmitted");
        pop_n(2 * NUM_PE, "admit_pop_b");

        wr(A_CMD, 0, 0, 32'h4); merr = '0;
        chk_status("err_cleared");

        // Load attempt while running
        wr(A_CMD, 0, 0, 32'h1);
        idle(2);
        wr(A_WGT, 1, 0, $urandom);
        merr[1] = 1'b1;
        idle(RUN_WAIT);
        model_run();
        chk_status("busy_write_err");
        pop_n(NUM_PE, "busy_write_pop");
        pop_one("pop_empty");
        chk_status("pop_empty_err");

        run();
        wr(A_CMD, 0, 0, 32'h3); mfifo.delete(); mdone = 0;
        chk_status("start_flush");
        idle(RUN_WAIT);
        chk_status("start_flush_no_run");
        wr(A_CMD, 0, 0, 32'h1);
        idle(3);
        wr(A_CMD, 0, 0, 32'h2);
        idle(RUN_WAIT);
        chk_status("flush_mid_run");

        // Async reset during RUN
        run();
        rd(A_CFGRD, m_cfg(), '1, "cfg_before_rst");
        wr(A_CMD, 0, 0, 32'h1);
        idle(5);
        #2 rst_ni = 1'b0;
        force_check(32'd0, "rst_douta");
        rst_ni = 1'b1;
        model_reset();
        chk_status("rst_status");
        rd(A_CFGRD, 32'd0, '1, "rst_cfg");
        pop_one("rst_fifo_empty");
        wr(A_CMD, 0, 0, 32'h4); merr = '0;

        for (int it = 0; it < 8; it++) begin
            for (int t = 0; t < TAPS; t++) begin
                mx[t] = int'($urandom_range(255));
                for (int p = 0; p < NUM_PE; p++) mw[p][t] = int'($urandom_range(255)) - 128;
            end
            load_x(); load_w();
            set_cfg(1'($urandom_range(1)), 1'($urandom_range(1)), int'($urandom_range(20)));
            run();
            pop_n(NUM_PE, "rand_pop");
        end
        chk_status("final_status");

        idle(2);
        end_req = 1'b1;
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
